ram_burst_master: RTL
=====================

Name: ram_burst_master

Overview:
- Initiator for the team's synchronous dual-port RAM interface: active-low chip select, write enable, output enable, separate read/write addresses, and a one-cycle registered read port that tri-states unless selected, output-enabled and not writing.
- Accepts burst commands (start address, length, direction) from a valid/ready upstream.
- Streams write data into the RAM and streams read data back out.
- Sequences cs/we/oe so the RAM's tri-state output is only sampled when the RAM is driving it.

Parameters:
- D_WIDTH, 16, RAM data width.
- A_WIDTH, 6, RAM address width; depth 2**A_WIDTH.
- TIMEOUT, 255, write-data stall limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE (combinational from state)
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  A_WIDTH  start address
- cmd_len  in  A_WIDTH  burst words minus 1 (1..2**A_WIDTH words)
- wdata_valid  in  1  write word offered
- wdata_ready  out  1  high only in WR state
- wdata  in  D_WIDTH  write word
- rdata_valid  out  1  one-cycle strobe per read word
- rdata  out  D_WIDTH  read word
- done  out  1  one-cycle pulse at burst completion
- ram_cs_n  out  1  RAM chip select, active low
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_raddr  out  A_WIDTH  RAM read address
- ram_waddr  out  A_WIDTH  RAM write address
- ram_d  out  D_WIDTH  RAM write data
- ram_q  in  D_WIDTH  RAM read data (tri-state bus)

Behaviour:
- Reset state (async, rst_n low): state IDLE.
  - ram_cs_n=1; ram_we=0; ram_oe=0.
  - ram_raddr, ram_waddr, ram_d, rdata = 0.
  - rdata_valid=0; done=0.
- Register policy: all RAM-side outputs, rdata, rdata_valid and done are registered. cmd_ready and wdata_ready are combinational from state only.
- Command accept: cmd_valid & cmd_ready at edge E0 latches cmd_write, cmd_addr and cmd_len. Later changes on cmd_* are ignored until the next IDLE.
- States: IDLE, WR, RD, RD_DRAIN.
- IDLE: ram_cs_n=1, we=0, oe=0. On accept: go to WR if write, else RD.
- WR:
  - ram_cs_n=0, ram_oe=0.
  - Each wdata handshake at edge k: ram_we=1, ram_waddr=current address, ram_d=wdata, all valid in cycle k+1. Address then increments.
  - Cycles without a handshake: ram_we=0.
  - The RAM commits each word at the end of cycle k+1.
  - Handshake of word cmd_len+1: done=1 and state IDLE in cycle k+1, so cmd_ready=1 in k+1.
- RD:
  - Cycles 1..N (N=cmd_len+1): ram_cs_n=0, ram_oe=1, ram_we=0, ram_raddr = start+i.
  - After the last address: go to RD_DRAIN for one cycle (cs/oe held, raddr held), then IDLE.
  - Capture: ram_q is sampled every cycle c in 2..N+1; the sampled word is presented as rdata with rdata_valid=1 in cycle c+1.
  - Result: rdata_valid is high for cycles 3..N+2, contiguous, with no backpressure.
  - done=1 in cycle N+2, coincident with the last rdata_valid; cmd_ready=1 in N+2.
- Invariant: ram_we and ram_oe are never both 1. ram_q is never sampled unless ram_cs_n=0, ram_oe=1 and ram_we=0 in that cycle.
- Address arithmetic: modulo 2**A_WIDTH, so 0x3F+1=0x00. cmd_len=all-ones covers the full depth exactly once.
- Word counter: A_WIDTH+1 bits; no overflow at full depth.
- Reset mid-burst: the burst aborts immediately with all outputs at reset values and no done pulse. A write already committed stays in the RAM.
- Back-to-back bursts: a new command may be accepted in the done cycle. No dead cycle is required between bursts.

Optional Feature:
- Macro: RAM_BURST_MASTER_TIMEOUT_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - In WR, a stall counter counts consecutive cycles without a wdata handshake and clears on each handshake.
  - At TIMEOUT stall cycles: err and done pulse together for one cycle, ram_we=0, state IDLE. Words already written remain in the RAM.
- Undefined: no err port, no counter; WR waits indefinitely.

Test Plan:
- Reset: assert rst_n low mid-cycle -> same cycle ram_cs_n=1, ram_we=0, ram_oe=0, rdata_valid=0, done=0; after release cmd_ready=1.
- Write burst: addr=0x3E, len=3, data 0x1111/0x2222/0x3333/0x4444, wdata_valid low for 2 cycles after word 2 -> RAM writes 0x3E,0x3F,0x00,0x01 in order; ram_we=0 during the gap; exactly one done.
- Read burst: addr=0x3E, len=3 after the above -> rdata_valid in cycles 3,4,5,6 after accept with rdata 0x1111,0x2222,0x3333,0x4444; done in cycle 6.
- Full depth: write ram[i]=i^0xA5A5 with len=63, then read with len=63 from addr 0x10 -> 64 contiguous correct words, wrapping at 0x3F->0x00.
- Back-to-back: read accepted in a write's done cycle, then write accepted in that read's done cycle -> no cycle with ram_we=1 and ram_oe=1; data correct.
- Abort: rst_n low during cycle 2 of a read burst with len=7 -> no further rdata_valid, no done; a fresh read of addr 0 with len=0 afterwards returns the correct word. With the macro and TIMEOUT=4: stall 4 cycles mid write burst -> err=done=1 for one cycle, then IDLE.

Source files
------------

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for the synchronous dual-port RAM.
// Accepts {addr, len, dir} commands, streams write words into the RAM and
// streams read words back out, keeping cs/we/oe sequenced so ram_q is only
// sampled while the RAM is actually driving it.
// Optional feature: define RAM_BURST_MASTER_TIMEOUT_EN to add the err port
// and a write-data stall timeout of TIMEOUT cycles.
module ram_burst_master #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 6,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [A_WIDTH-1:0] cmd_len,
    input  logic               wdata_valid,
    output logic               wdata_ready,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               rdata_valid,
    output logic [D_WIDTH-1:0] rdata,
    output logic               done,
    output logic               ram_cs_n,
    output logic               ram_we,
    output logic               ram_oe,
    output logic [A_WIDTH-1:0] ram_raddr,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [D_WIDTH-1:0] ram_d,
    input  logic [D_WIDTH-1:0] ram_q
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD       = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t               r_state, w_state;
    logic                 r_cs_n, w_cs_n;
    logic                 r_we, w_we;
    logic                 r_oe, w_oe;
    logic [A_WIDTH-1:0]   r_raddr, w_raddr;
    logic [A_WIDTH-1:0]   r_waddr, w_waddr;
    logic [D_WIDTH-1:0]   r_d, w_d;
    logic                 r_done, w_done;
    logic [A_WIDTH-1:0]   r_addr, w_addr;     // next write address
    logic [A_WIDTH-1:0]   r_len, w_len;       // latched burst length - 1
    logic [A_WIDTH:0]     r_cnt, w_cnt;       // words handled so far (0-based)
    logic                 r_q_pend;           // RAM is presenting a read word this cycle
    logic                 r_rvalid;
    logic [D_WIDTH-1:0]   r_rdata;
    logic                 w_wfire;
    logic [A_WIDTH:0]     w_len_ext;

`ifdef RAM_BURST_MASTER_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT + 1);
    logic [ST_W-1:0]      r_stall, w_stall;
    logic                 r_err, w_err;
`endif

    assign w_wfire   = (r_state == WR) && wdata_valid;
    assign w_len_ext = {1'b0, r_len};

    // Next-state and next registered RAM-side outputs
    always_comb begin
        w_state = r_state;
        w_cs_n  = 1'b1;
        w_we    = 1'b0;
        w_oe    = 1'b0;
        w_raddr = r_raddr;
        w_waddr = r_waddr;
        w_d     = r_d;
        w_done  = 1'b0;
        w_addr  = r_addr;
        w_len   = r_len;
        w_cnt   = r_cnt;
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
        w_stall = '0;
        w_err   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_len  = cmd_len;
                    w_cnt  = '0;
                    w_cs_n = 1'b0;
                    if (cmd_write) begin
                        w_state = WR;
                        w_addr  = cmd_addr;
                    end else begin
                        // First read address goes out in the cycle after accept
                        w_state = RD;
                        w_oe    = 1'b1;
                        w_raddr = cmd_addr;
                    end
                end
            end
            WR: begin
                // cs stays low for the cycle carrying the last write, even
                // though the state has already returned to IDLE by then
                w_cs_n = 1'b0;
                if (w_wfire) begin
                    w_we    = 1'b1;
                    w_waddr = r_addr;
                    w_d     = wdata;
                    w_addr  = r_addr + 1'b1;
                    w_cnt   = r_cnt + 1'b1;
                    if (r_cnt == w_len_ext) begin
                        w_state = IDLE;
                        w_done  = 1'b1;
                    end
                end
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
                else if (r_stall == ST_W'(TIMEOUT - 1)) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                    w_err   = 1'b1;
                    w_cs_n  = 1'b1;
                end else begin
                    w_stall = r_stall + 1'b1;
                end
`endif
            end
            RD: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                if (r_cnt == w_len_ext) begin
                    w_state = RD_DRAIN;
                end else begin
                    w_raddr = r_raddr + 1'b1;
                    w_cnt   = r_cnt + 1'b1;
                end
            end
            RD_DRAIN: begin
                // Hold cs/oe so the last word is still driven when captured
                w_cs_n  = 1'b0;
                w_oe    = 1'b1;
                w_state = IDLE;
                w_done  = 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end

    // State and RAM-side output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_d     <= '0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
            r_stall <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_cs_n  <= w_cs_n;
            r_we    <= w_we;
            r_oe    <= w_oe;
            r_raddr <= w_raddr;
            r_waddr <= w_waddr;
            r_d     <= w_d;
            r_done  <= w_done;
            r_addr  <= w_addr;
            r_len   <= w_len;
            r_cnt   <= w_cnt;
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
            r_stall <= w_stall;
            r_err   <= w_err;
`endif
        end
    end

    // Read capture: a cycle spent in RD means ram_q carries that word one
    // cycle later (the drain cycle covers the last one); present it a cycle after that
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_pend <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_q_pend <= (r_state == RD);
            r_rvalid <= r_q_pend;
            if (r_q_pend) begin
                r_rdata <= ram_q;
            end
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign wdata_ready = (r_state == WR);
    assign rdata_valid = r_rvalid;
    assign rdata       = r_rdata;
    assign done        = r_done;
    assign ram_cs_n    = r_cs_n;
    assign ram_we      = r_we;
    assign ram_oe      = r_oe;
    assign ram_raddr   = r_raddr;
    assign ram_waddr   = r_waddr;
    assign ram_d       = r_d;
`ifdef RAM_BURST_MASTER_TIMEOUT_EN
    assign err         = r_err;
`endif

endmodule
